td4_prog_loader: RTL and testbench

Serial program loader for the TD4 core: receives a framed program image over a UART line and writes it into the 16 x 8 instruction memory through that memory's write port, the write-side counterpart to the CPU's instruction fetch. It holds the CPU in reset from power-up or reload start until an image with a valid checksum has been written, then releases it. It sits between the board UART pin and the instruction memory, beside the TD4 top.

---
 rtl/td4_prog_loader_pkg.sv | 23 ++
 rtl/td4_uart_rx.sv | 96 +++++++++
 rtl/td4_prog_loader.sv | 116 +++++++++++
 tb/tb_td4_prog_loader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/td4_prog_loader_pkg.sv
// Shared definitions for the TD4 serial program loader: state encodings,
// default frame marker and instruction memory geometry.
package td4_prog_loader_pkg;

  localparam int TD4_MEM_DEPTH = 16;
  localparam int TD4_ADDR_W    = 4;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    LOAD      = 2'd1,
    CHECK     = 2'd2
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/td4_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, start-bit glitch rejection and
// mid-bit sampling. byte_valid / frame_err are single-cycle pulses.
module td4_uart_rx
  import td4_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic            rx_meta, rx_s, rx_d;
  rx_state_t       state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shift, shift_n;
  logic            valid_n, ferr_n;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_d       <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rxd;
      rx_s       <= rx_meta;
      rx_d       <= rx_s;
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shift      <= shift_n;
      byte_valid <= valid_n;
      frame_err  <= ferr_n;
    end
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (rx_d && !rx_s) state_n = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? RX_IDLE : RX_DATA;  // high at mid-start is a glitch
        end
      end
      RX_DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_n     = '0;
          shift_n   = {rx_s, shift[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_n   = '0;
          state_n = RX_IDLE;
          valid_n = rx_s;
          ferr_n  = !rx_s;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  assign byte_data = shift;

endmodule

// File: rtl/td4_prog_loader.sv
// TD4 program loader: takes a framed 16-byte image from the UART, writes it
// to instruction memory and holds the CPU in reset until the checksum passes.
module td4_prog_loader
  import td4_prog_loader_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rxd,
  output logic                  mem_we,
  output logic [TD4_ADDR_W-1:0] mem_waddr,
  output logic [7:0]            mem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [TD4_ADDR_W-1:0] LAST_ADDR = TD4_ADDR_W'(TD4_MEM_DEPTH - 1);

  logic       byte_valid, frame_err;
  logic [7:0] byte_data;

  td4_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  loader_state_t         state, state_n;
  logic [TD4_ADDR_W-1:0] addr, addr_n, waddr_n;
  logic [7:0]            sum, sum_n, wdata_n;
  logic                  we_n, hold_n, busy_n, done_n, err_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= WAIT_SYNC;
      addr      <= '0;
      sum       <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      sum       <= sum_n;
      mem_we    <= we_n;
      mem_waddr <= waddr_n;
      mem_wdata <= wdata_n;
      cpu_hold  <= hold_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = addr;
    sum_n   = sum;
    we_n    = 1'b0;
    waddr_n = mem_waddr;
    wdata_n = mem_wdata;
    hold_n  = cpu_hold;
    busy_n  = busy;
    done_n  = 1'b0;
    err_n   = err;
    case (state)
      WAIT_SYNC: begin
        if (byte_valid && byte_data == SYNC_BYTE) begin
          state_n = LOAD;
          addr_n  = '0;
          sum_n   = '0;
          hold_n  = 1'b1;
          busy_n  = 1'b1;
          err_n   = 1'b0;
        end
      end
      LOAD, CHECK: begin
        if (frame_err) begin
          // A broken byte aborts the frame; memory stays partially written.
          state_n = WAIT_SYNC;
          busy_n  = 1'b0;
          err_n   = 1'b1;
        end else if (byte_valid && state == LOAD) begin
          we_n    = 1'b1;
          waddr_n = addr;
          wdata_n = byte_data;
          sum_n   = sum + byte_data;
          if (addr == LAST_ADDR) state_n = CHECK;
          else                   addr_n  = addr + 1'b1;
        end else if (byte_valid) begin
          state_n = WAIT_SYNC;
          busy_n  = 1'b0;
          if (byte_data == sum) begin
            done_n = 1'b1;
            hold_n = 1'b0;
          end else begin
            err_n  = 1'b1;
          end
        end
      end
      default: state_n = WAIT_SYNC;
    endcase
  end

endmodule

// File: tb/tb_td4_prog_loader.sv
// Self-checking bench for td4_prog_loader: serial frames are driven on rxd,
// expected memory writes are queued and compared against observed writes.
module tb_td4_prog_loader;

  localparam int CPB = 16;

  typedef logic [7:0] image_t [16];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic       mem_we;
  logic [3:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       cpu_hold, busy, done, err;

  td4_prog_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk      (clk),
    .reset    (reset),
    .rxd      (rxd),
    .mem_we   (mem_we),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [11:0] sb[$];   // expected {addr, data}
  logic [11:0] obs[$];  // observed {addr, data}
  int done_cnt      = 0;
  int done_hold_bad = 0;

  always @(negedge clk) begin
    if (mem_we) obs.push_back({mem_waddr, mem_wdata});
    if (done) begin
      done_cnt++;
      if (cpu_hold) done_hold_bad++;
    end
  end

  function automatic logic [7:0] image_sum(input image_t img);
    logic [7:0] s = 8'h00;
    foreach (img[i]) s = s + img[i];
    return s;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge clk) rxd = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) rxd = b[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk) rxd = stop_ok;
    repeat (CPB - 1) @(negedge clk);
    @(negedge clk) rxd = 1'b1;
  endtask

  task automatic drain_writes(input string name);
    logic [11:0] e, o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      compared++;
      if (obs.size() == 0) begin
        mismatched++;
        $display("FAIL %s_missing_write: got none, expected addr=%0d data=%h", name, e[11:8], e[7:0]);
      end else begin
        o = obs.pop_front();
        if (o !== e) begin
          mismatched++;
          $display("FAIL %s_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   name, o[11:8], o[7:0], e[11:8], e[7:0]);
        end
      end
    end
    compared++;
    if (obs.size() != 0) begin
      mismatched++;
      $display("FAIL %s_extra_writes: got %0d unexpected writes, expected 0", name, obs.size());
      obs.delete();
    end
  endtask

  task automatic run_frame(input image_t img, input logic [7:0] csum, input string name);
    send_byte(8'hA5, 1'b1);
    compared++;
    if ({cpu_hold, busy, err} !== 3'b110) begin
      mismatched++;
      $display("FAIL %s_after_sync: hold/busy/err=%b, expected 110", name, {cpu_hold, busy, err});
    end
    for (int i = 0; i < 16; i++) begin
      sb.push_back({4'(i), img[i]});
      send_byte(img[i], 1'b1);
    end
    send_byte(csum, 1'b1);
    repeat (4) @(negedge clk);
    drain_writes(name);
  endtask

  function automatic image_t ramp_image();
    image_t img;
    foreach (img[i]) img[i] = 8'(i);
    return img;
  endfunction

  task automatic test_good_frame_status(input string name, input int d0);
    compared++;
    if (done_cnt - d0 != 1) begin
      mismatched++;
      $display("FAIL %s_done: got %0d done pulses, expected 1", name, done_cnt - d0);
    end
    compared++;
    if ({cpu_hold, busy, err} !== 3'b000) begin
      mismatched++;
      $display("FAIL %s_status: hold/busy/err=%b, expected 000", name, {cpu_hold, busy, err});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if ({cpu_hold, mem_we, mem_waddr, mem_wdata, busy, done, err} !== {1'b1, 1'b0, 4'h0, 8'h00, 3'b000}) begin
      mismatched++;
      $display("FAIL reset_values: hold=%b we=%b addr=%h data=%h busy=%b done=%b err=%b, expected 1 0 0 00 0 0 0",
               cpu_hold, mem_we, mem_waddr, mem_wdata, busy, done, err);
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_good_image();
    int d0 = done_cnt;
    image_t img = ramp_image();
    run_frame(img, image_sum(img), "good");
    test_good_frame_status("good", d0);
    compared++;
    if (done_hold_bad != 0) begin
      mismatched++;
      $display("FAIL good_done_hold: cpu_hold high during %0d done pulses, expected 0", done_hold_bad);
    end
  endtask

  task automatic test_bad_checksum();
    int d0 = done_cnt;
    image_t img = ramp_image();
    run_frame(img, 8'h79, "badsum");
    compared++;
    if (done_cnt != d0) begin
      mismatched++;
      $display("FAIL badsum_done: got %0d done pulses, expected 0", done_cnt - d0);
    end
    compared++;
    if ({cpu_hold, busy, err} !== 3'b101) begin
      mismatched++;
      $display("FAIL badsum_status: hold/busy/err=%b, expected 101", {cpu_hold, busy, err});
    end
    d0 = done_cnt;
    run_frame(img, 8'h78, "badsum_recover");
    test_good_frame_status("badsum_recover", d0);
  endtask

  task automatic test_noise();
    int d0;
    image_t img = ramp_image();
    send_byte(8'h12, 1'b1);
    send_byte(8'hFF, 1'b1);
    @(negedge clk) rxd = 1'b0;
    @(negedge clk) rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    drain_writes("noise_pre_sync");
    d0 = done_cnt;
    run_frame(img, image_sum(img), "noise");
    test_good_frame_status("noise", d0);
  endtask

  task automatic test_frame_error();
    int d0 = done_cnt;
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      sb.push_back({4'(i), 8'(i)});
      send_byte(8'(i), 1'b1);
    end
    send_byte(8'h05, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    drain_writes("frame_err");
    compared++;
    if ({cpu_hold, busy, err} !== 3'b101) begin
      mismatched++;
      $display("FAIL frame_err_status: hold/busy/err=%b, expected 101", {cpu_hold, busy, err});
    end
    // Back in WAIT_SYNC: ordinary bytes must not be written.
    send_byte(8'h06, 1'b1);
    send_byte(8'h07, 1'b1);
    repeat (4) @(negedge clk);
    drain_writes("frame_err_idle");
    compared++;
    if (done_cnt != d0) begin
      mismatched++;
      $display("FAIL frame_err_done: got %0d done pulses, expected 0", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_load();
    int d0 = done_cnt;
    image_t img = ramp_image();
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 7; i++) begin
      sb.push_back({4'(i), img[i]});
      send_byte(img[i], 1'b1);
    end
    drain_writes("rst_mid_pre");
    @(negedge clk) reset = 1'b1;
    #1;
    compared++;
    if ({cpu_hold, mem_we, mem_waddr, mem_wdata, busy, done, err} !== {1'b1, 1'b0, 4'h0, 8'h00, 3'b000}) begin
      mismatched++;
      $display("FAIL rst_mid_values: hold=%b we=%b addr=%h data=%h busy=%b done=%b err=%b, expected 1 0 0 00 0 0 0",
               cpu_hold, mem_we, mem_waddr, mem_wdata, busy, done, err);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 7; i < 16; i++) send_byte(img[i], 1'b1);
    send_byte(image_sum(img), 1'b1);
    repeat (4) @(negedge clk);
    drain_writes("rst_mid_tail");
    compared++;
    if (done_cnt != d0 || cpu_hold !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_mid_tail_status: done pulses=%0d hold=%b, expected 0 and 1", done_cnt - d0, cpu_hold);
    end
    d0 = done_cnt;
    run_frame(img, image_sum(img), "rst_mid_fresh");
    test_good_frame_status("rst_mid_fresh", d0);
  endtask

  task automatic test_reload();
    int d0 = done_cnt;
    image_t img = ramp_image();
    image_t b0;
    foreach (b0[i]) b0[i] = 8'hB0;
    run_frame(img, image_sum(img), "reload_first");
    test_good_frame_status("reload_first", d0);
    d0 = done_cnt;
    run_frame(b0, 8'h00, "reload_second");
    test_good_frame_status("reload_second", d0);
  endtask

  initial begin
    test_reset();
    test_good_image();
    test_bad_checksum();
    test_noise();
    test_frame_error();
    test_reset_mid_load();
    test_reload();
    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
